// File: rtl/node_word_serializer_if.sv
// Node description package plus the two stream interfaces of node_word_serializer.
//
// node_pkg      : rule_s / node_s layouts and the flat-image bit offsets.
//                 A node_s cast to a bit vector puts node_type at bit 0, followed
//                 by range, rule_count, rules[], child_count and children[].
// node_in_if    : node producer -> serializer. The producer drives valid, node and
//                 addr, where addr is the word address of word 0. The serializer
//                 drives ready.
// word_out_if   : serializer -> node RAM write port. The serializer drives valid,
//                 data, addr and last. The memory drives ready.
package node_pkg;
  localparam int RULE_W                = 32;
  localparam int CHILD_W               = 32;
  localparam int COUNT_W               = 3;
  localparam int MAX_RULES_PER_NODE    = 4;
  localparam int MAX_CHILDREN_PER_NODE = 4;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } rule_s;

  // The first member of a packed struct is the MSB side, so fields are listed in
  // reverse of the flat layout.
  typedef struct packed {
    logic [MAX_CHILDREN_PER_NODE-1:0][CHILD_W-1:0] children;
    logic [COUNT_W-1:0]                            child_count;
    rule_s [MAX_RULES_PER_NODE-1:0]                rules;
    logic [COUNT_W-1:0]                            rule_count;
    rule_s                                         range;
    logic [1:0]                                    node_type;
  } node_s;

  localparam int NODE_TYPE_OFFSET   = 0;
  localparam int RANGE_OFFSET       = 2;
  localparam int RULE_COUNT_OFFSET  = RANGE_OFFSET + RULE_W;
  localparam int RULES_OFFSET       = RULE_COUNT_OFFSET + COUNT_W;
  localparam int CHILD_COUNT_OFFSET = RULES_OFFSET + MAX_RULES_PER_NODE * RULE_W;
  localparam int CHILDREN_OFFSET    = CHILD_COUNT_OFFSET + COUNT_W;
  localparam int NODE_BITS          = $bits(node_s);
endpackage

interface node_in_if #(parameter int ADDR_W = 16);
  logic                valid;
  logic                ready;
  node_pkg::node_s     node;
  logic [ADDR_W-1:0]   addr;

  modport master (output valid, output node, output addr, input ready);
  modport slave  (input valid, input node, input addr, output ready);
endinterface

interface word_out_if #(parameter int WORD_W = 32, parameter int ADDR_W = 16);
  logic                valid;
  logic                ready;
  logic [WORD_W-1:0]   data;
  logic [ADDR_W-1:0]   addr;
  logic                last;

  modport master (output valid, output data, output addr, output last, input ready);
  modport slave  (input valid, input data, input addr, input last, output ready);
endinterface

// File: rtl/node_word_serializer.sv
// node_word_serializer: latches one node_s and streams its flat bit image to node
// memory as NUM_WORDS words of WORD_W bits. The words go out LSB word first, at
// consecutive addresses that start at the node's base address.
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   node_if     : node_in_if.slave. The node stream comes in with valid/ready.
//                 addr is the word address of word 0.
//   word_if     : word_out_if.master. The word stream goes out with valid/ready.
//                 addr advances by 1 per word and wraps modulo 2^ADDR_W.
//                 last marks word NUM_WORDS-1.
//   node_done_o : 1-cycle pulse on the cycle after the last word is accepted
//   fmt_err_o   : sticky. It is set when a node with rule_count or child_count
//                 above the per-node maximum is accepted. Only reset clears it.
module node_word_serializer
  import node_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  node_in_if.slave     node_if,
  word_out_if.master   word_if,
  output logic         node_done_o,
  output logic         fmt_err_o
);

  localparam int NUM_WORDS = (NODE_BITS + WORD_W - 1) / WORD_W;
  localparam int IMG_W     = NUM_WORDS * WORD_W;
  localparam int KW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0]      LAST_K = KW'(NUM_WORDS - 1);
  localparam logic [COUNT_W-1:0] MAX_RC = COUNT_W'(MAX_RULES_PER_NODE);
  localparam logic [COUNT_W-1:0] MAX_CC = COUNT_W'(MAX_CHILDREN_PER_NODE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state_q;
  logic [KW-1:0]     k_q;
  logic [IMG_W-1:0]  image_q;
  logic              node_ready_q;
  logic              word_valid_q;
  logic [WORD_W-1:0] word_data_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic              word_last_q;
  logic              node_done_q;
  logic              fmt_err_q;

  logic [IMG_W-1:0]  image_d;
  logic [KW-1:0]     k_d;
  logic              fmt_bad_d;

  function automatic logic [WORD_W-1:0] word_of(input logic [IMG_W-1:0] img,
                                                input logic [KW-1:0]    idx);
    return img[int'(idx) * WORD_W +: WORD_W];
  endfunction

  // The incoming node is zero-padded up to a whole number of words.
  always_comb begin
    image_d                  = '0;
    image_d[NODE_BITS-1:0]   = node_if.node;
  end

  assign k_d       = k_q + KW'(1);
  assign fmt_bad_d = (node_if.node.rule_count > MAX_RC) ||
                     (node_if.node.child_count > MAX_CC);

  // Control FSM. All outputs are registered, so word k is presented directly
  // from word_data_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      image_q      <= '0;
      node_ready_q <= 1'b1;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_addr_q  <= '0;
      word_last_q  <= 1'b0;
      node_done_q  <= 1'b0;
      fmt_err_q    <= 1'b0;
    end else begin
      node_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (node_if.valid && node_ready_q) begin
            // Latch the image so node_in may change freely after acceptance.
            image_q      <= image_d;
            k_q          <= '0;
            word_data_q  <= word_of(image_d, '0);
            word_addr_q  <= node_if.addr;
            word_last_q  <= (NUM_WORDS == 1);
            word_valid_q <= 1'b1;
            node_ready_q <= 1'b0;
            fmt_err_q    <= fmt_err_q | fmt_bad_d;
            state_q      <= ST_SEND;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (word_if.ready && word_last_q) begin
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            node_ready_q <= 1'b1;
            node_done_q  <= 1'b1;
            k_q          <= '0;
            state_q      <= ST_IDLE;
          end else if (word_if.ready) begin
            k_q         <= k_d;
            word_data_q <= word_of(image_q, k_d);
            word_addr_q <= word_addr_q + ADDR_W'(1);
            word_last_q <= (k_d == LAST_K);
          end else begin
            // Stalled: hold everything so the memory sees a stable word.
            state_q <= ST_SEND;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          node_ready_q <= 1'b1;
          word_valid_q <= 1'b0;
          word_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign node_if.ready = node_ready_q;
  assign word_if.valid = word_valid_q;
  assign word_if.data  = word_data_q;
  assign word_if.addr  = word_addr_q;
  assign word_if.last  = word_last_q;
  assign node_done_o   = node_done_q;
  assign fmt_err_o     = fmt_err_q;

endmodule

// File: tb/tb_node_word_serializer.sv
// Self-checking bench for node_word_serializer. Each node is built field by field
// at the offsets of the flat layout. The returned words are checked against that
// image, and are also re-assembled and unpacked field by field.
module tb_node_word_serializer;
  import node_pkg::*;

  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 16;
  localparam int NUM_WORDS = (NODE_BITS + WORD_W - 1) / WORD_W;
  localparam int IMG_W     = NUM_WORDS * WORD_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic node_done;
  logic fmt_err;

  always #5 clk = ~clk;

  node_in_if  #(.ADDR_W(ADDR_W))                   nif ();
  word_out_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W))  wif ();

  node_word_serializer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .node_if     (nif),
    .word_if     (wif),
    .node_done_o (node_done),
    .fmt_err_o   (fmt_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Fields of the node currently being generated.
  logic [1:0]         f_type;
  logic [RULE_W-1:0]  f_range;
  logic [COUNT_W-1:0] f_rc;
  logic [COUNT_W-1:0] f_cc;
  logic [RULE_W-1:0]  f_rules    [MAX_RULES_PER_NODE];
  logic [CHILD_W-1:0] f_children [MAX_CHILDREN_PER_NODE];

  // Results collected by send_node.
  logic [WORD_W-1:0] got_data [$];
  logic [ADDR_W-1:0] got_addr [$];
  logic              got_last [$];
  int  stall_bad, busy_ready_bad, done_early;
  int  first_acc_cyc, last_acc_cyc, word0_cyc;
  bit  lat_ok, timed_out;
  logic done_now, ready_now, valid_now;

  task automatic rand_fields(input int max_rc, input int max_cc);
    f_type  = 2'($urandom_range(0, 3));
    f_range = $urandom;
    f_rc    = COUNT_W'($urandom_range(0, max_rc));
    f_cc    = COUNT_W'($urandom_range(0, max_cc));
    for (int j = 0; j < MAX_RULES_PER_NODE; j++)    f_rules[j]    = $urandom;
    for (int j = 0; j < MAX_CHILDREN_PER_NODE; j++) f_children[j] = $urandom;
  endtask

  function automatic logic [IMG_W-1:0] build_flat();
    logic [IMG_W-1:0] f;
    f = '0;
    f[NODE_TYPE_OFFSET +: 2]         = f_type;
    f[RANGE_OFFSET +: RULE_W]        = f_range;
    f[RULE_COUNT_OFFSET +: COUNT_W]  = f_rc;
    for (int j = 0; j < MAX_RULES_PER_NODE; j++)
      f[RULES_OFFSET + j * RULE_W +: RULE_W] = f_rules[j];
    f[CHILD_COUNT_OFFSET +: COUNT_W] = f_cc;
    for (int j = 0; j < MAX_CHILDREN_PER_NODE; j++)
      f[CHILDREN_OFFSET + j * CHILD_W +: CHILD_W] = f_children[j];
    return f;
  endfunction

  // Presents one node and collects its words. mode 0 holds ready at 1, mode 1
  // uses the pattern 1,0,0 repeating, and mode 2 is random. The only checks made
  // here are the per-cycle protocol counts. The calling scenario compares them.
  task automatic send_node(input logic [IMG_W-1:0] flat, input logic [ADDR_W-1:0] base,
                           input int mode);
    logic [WORD_W-1:0] h_data;
    logic [ADDR_W-1:0] h_addr;
    logic              h_last;
    bit                stalled;
    bit                fin;
    int                n;
    got_data.delete(); got_addr.delete(); got_last.delete();
    stall_bad = 0; busy_ready_bad = 0; done_early = 0; timed_out = 1'b0;
    first_acc_cyc = 0; last_acc_cyc = 0;
    h_data = '0; h_addr = '0; h_last = 1'b0;
    n = 0;
    while (nif.ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (nif.ready !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    nif.valid = 1'b1;
    nif.node  = node_s'(flat[NODE_BITS-1:0]);
    nif.addr  = base;
    @(posedge clk); #1;
    nif.valid = 1'b0;
    nif.node  = node_s'(~flat[NODE_BITS-1:0]);
    nif.addr  = ~base;
    lat_ok    = (wif.valid === 1'b1);
    word0_cyc = cyc;
    stalled   = 1'b0;
    fin       = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (stalled && (wif.data !== h_data || wif.addr !== h_addr ||
                      wif.last !== h_last || wif.valid !== 1'b1)) stall_bad++;
      if (nif.ready !== 1'b0) busy_ready_bad++;
      if (node_done !== 1'b0) done_early++;
      case (mode)
        0:       wif.ready = 1'b1;
        1:       wif.ready = (c % 3 == 0);
        default: wif.ready = 1'($urandom_range(0, 1));
      endcase
      if (wif.valid === 1'b1 && wif.ready) begin
        got_data.push_back(wif.data);
        got_addr.push_back(wif.addr);
        got_last.push_back(wif.last);
        if (got_data.size() == 1) first_acc_cyc = cyc;
        if (wif.last === 1'b1 || got_data.size() >= NUM_WORDS + 4) begin
          fin = 1'b1;
          last_acc_cyc = cyc;
        end
        stalled = 1'b0;
      end else begin
        stalled = (wif.valid === 1'b1);
        h_data  = wif.data;
        h_addr  = wif.addr;
        h_last  = wif.last;
      end
      @(posedge clk); #1;
    end
    wif.ready = 1'b0;
    if (!fin) timed_out = 1'b1;
    done_now  = node_done;
    ready_now = nif.ready;
    valid_now = wif.valid;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    checks++; if (nif.ready !== 1'b1)  begin errors++; $display("FAIL rst_node_ready got %b exp 1", nif.ready); end
    checks++; if (wif.valid !== 1'b0)  begin errors++; $display("FAIL rst_word_valid got %b exp 0", wif.valid); end
    checks++; if (wif.data !== '0)     begin errors++; $display("FAIL rst_word_data got %h exp 0", wif.data); end
    checks++; if (wif.addr !== '0)     begin errors++; $display("FAIL rst_word_addr got %h exp 0", wif.addr); end
    checks++; if (wif.last !== 1'b0)   begin errors++; $display("FAIL rst_word_last got %b exp 0", wif.last); end
    checks++; if (node_done !== 1'b0)  begin errors++; $display("FAIL rst_node_done got %b exp 0", node_done); end
    checks++; if (fmt_err !== 1'b0)    begin errors++; $display("FAIL rst_fmt_err got %b exp 0", fmt_err); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_leaf();
    logic [IMG_W-1:0] flat;
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    f_type = 2'b10;
    f_rc   = COUNT_W'(1);
    flat   = build_flat();
    send_node(flat, 16'h0100, 0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL leaf_timeout got %b exp 0", timed_out); end
    checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL leaf_latency got %b exp 1", lat_ok); end
    checks++; if (got_data.size() != NUM_WORDS) begin errors++; $display("FAIL leaf_count got %0d exp %0d", got_data.size(), NUM_WORDS); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== flat[i * WORD_W +: WORD_W]) begin errors++; $display("FAIL leaf_data[%0d] got %h exp %h", i, got_data[i], flat[i * WORD_W +: WORD_W]); end
      checks++; if (got_addr[i] !== ADDR_W'(16'h0100 + i)) begin errors++; $display("FAIL leaf_addr[%0d] got %h exp %h", i, got_addr[i], 16'h0100 + i); end
      checks++; if (got_last[i] !== (i == NUM_WORDS - 1)) begin errors++; $display("FAIL leaf_last[%0d] got %b exp %b", i, got_last[i], i == NUM_WORDS - 1); end
    end
    if (got_data.size() > 0) begin
      checks++; if (got_data[0][1:0] !== 2'b10) begin errors++; $display("FAIL leaf_type got %b exp 10", got_data[0][1:0]); end
    end
    checks++; if (last_acc_cyc - first_acc_cyc != NUM_WORDS - 1) begin errors++; $display("FAIL leaf_rate got %0d exp %0d", last_acc_cyc - first_acc_cyc, NUM_WORDS - 1); end
    checks++; if (done_early != 0) begin errors++; $display("FAIL leaf_done_early got %0d exp 0", done_early); end
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL leaf_done got %b exp 1", done_now); end
    checks++; if (ready_now !== 1'b1 || valid_now !== 1'b0) begin errors++; $display("FAIL leaf_idle got ready=%b valid=%b exp 1/0", ready_now, valid_now); end
    @(posedge clk); #1;
    checks++; if (node_done !== 1'b0) begin errors++; $display("FAIL leaf_done_pulse got %b exp 0", node_done); end
  endtask

  task automatic test_round_trip();
    logic [IMG_W-1:0]  flat;
    logic [IMG_W-1:0]  img;
    logic [ADDR_W-1:0] base;
    for (int t = 0; t < 4; t++) begin
      rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
      flat = build_flat();
      base = ADDR_W'($urandom);
      send_node(flat, base, 2);
      checks++; if (got_data.size() != NUM_WORDS || timed_out) begin errors++; $display("FAIL rt_count[%0d] got %0d exp %0d", t, got_data.size(), NUM_WORDS); end
      img = '0;
      for (int i = 0; i < NUM_WORDS && i < got_data.size(); i++) img[i * WORD_W +: WORD_W] = got_data[i];
      checks++; if (img[NODE_TYPE_OFFSET +: 2] !== f_type) begin errors++; $display("FAIL rt_type[%0d] got %h exp %h", t, img[NODE_TYPE_OFFSET +: 2], f_type); end
      checks++; if (img[RANGE_OFFSET +: RULE_W] !== f_range) begin errors++; $display("FAIL rt_range[%0d] got %h exp %h", t, img[RANGE_OFFSET +: RULE_W], f_range); end
      checks++; if (img[RULE_COUNT_OFFSET +: COUNT_W] !== f_rc) begin errors++; $display("FAIL rt_rc[%0d] got %h exp %h", t, img[RULE_COUNT_OFFSET +: COUNT_W], f_rc); end
      checks++; if (img[CHILD_COUNT_OFFSET +: COUNT_W] !== f_cc) begin errors++; $display("FAIL rt_cc[%0d] got %h exp %h", t, img[CHILD_COUNT_OFFSET +: COUNT_W], f_cc); end
      for (int j = 0; j < MAX_RULES_PER_NODE; j++) begin
        checks++; if (img[RULES_OFFSET + j * RULE_W +: RULE_W] !== f_rules[j]) begin errors++; $display("FAIL rt_rule[%0d][%0d] got %h exp %h", t, j, img[RULES_OFFSET + j * RULE_W +: RULE_W], f_rules[j]); end
      end
      for (int j = 0; j < MAX_CHILDREN_PER_NODE; j++) begin
        checks++; if (img[CHILDREN_OFFSET + j * CHILD_W +: CHILD_W] !== f_children[j]) begin errors++; $display("FAIL rt_child[%0d][%0d] got %h exp %h", t, j, img[CHILDREN_OFFSET + j * CHILD_W +: CHILD_W], f_children[j]); end
      end
      checks++; if (img[IMG_W-1:NODE_BITS] !== '0) begin errors++; $display("FAIL rt_pad[%0d] got %h exp 0", t, img[IMG_W-1:NODE_BITS]); end
      checks++; if (got_addr.size() > 0 && got_addr[0] !== base) begin errors++; $display("FAIL rt_addr0[%0d] got %h exp %h", t, got_addr[0], base); end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL rt_stable[%0d] got %0d exp 0", t, stall_bad); end
    end
    checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL rt_fmt_err got %b exp 0", fmt_err); end
  endtask

  task automatic test_stall();
    logic [IMG_W-1:0] flat;
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    flat = build_flat();
    send_node(flat, 16'h2000, 1);
    checks++; if (got_data.size() != NUM_WORDS || timed_out) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_data.size(), NUM_WORDS); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== flat[i * WORD_W +: WORD_W] || got_addr[i] !== ADDR_W'(16'h2000 + i)) begin errors++; $display("FAIL stall_word[%0d] got %h@%h exp %h@%h", i, got_data[i], got_addr[i], flat[i * WORD_W +: WORD_W], 16'h2000 + i); end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d exp 0", stall_bad); end
    checks++; if (busy_ready_bad != 0) begin errors++; $display("FAIL stall_node_ready got %0d exp 0", busy_ready_bad); end
    checks++; if (done_early != 0 || done_now !== 1'b1) begin errors++; $display("FAIL stall_done got early=%0d now=%b exp 0/1", done_early, done_now); end
  endtask

  task automatic test_back_to_back();
    logic [IMG_W-1:0] flat;
    int prev_last;
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    send_node(build_flat(), 16'h3000, 0);
    prev_last = last_acc_cyc;
    checks++; if (done_now !== 1'b1 || ready_now !== 1'b1) begin errors++; $display("FAIL b2b_first_done got done=%b ready=%b exp 1/1", done_now, ready_now); end
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    flat = build_flat();
    send_node(flat, 16'h4000, 0);
    checks++; if (word0_cyc - prev_last != 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", word0_cyc - prev_last); end
    checks++; if (got_data.size() != NUM_WORDS) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_data.size(), NUM_WORDS); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== flat[i * WORD_W +: WORD_W]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got_data[i], flat[i * WORD_W +: WORD_W]); end
    end
  endtask

  task automatic test_addr_wrap();
    logic [IMG_W-1:0] flat;
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    flat = build_flat();
    send_node(flat, 16'hFFFE, 0);
    checks++; if (got_addr.size() != NUM_WORDS) begin errors++; $display("FAIL wrap_count got %0d exp %0d", got_addr.size(), NUM_WORDS); end
    for (int i = 0; i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== ADDR_W'((65534 + i) % 65536)) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, got_addr[i], (65534 + i) % 65536); end
    end
    checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL wrap_fmt_err got %b exp 0", fmt_err); end
  endtask

  task automatic test_fmt_err();
    logic [IMG_W-1:0] flat;
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    f_rc = COUNT_W'(MAX_RULES_PER_NODE + 1);
    flat = build_flat();
    send_node(flat, 16'h5000, 0);
    checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_set got %b exp 1", fmt_err); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== flat[i * WORD_W +: WORD_W]) begin errors++; $display("FAIL fmt_verbatim[%0d] got %h exp %h", i, got_data[i], flat[i * WORD_W +: WORD_W]); end
    end
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    flat = build_flat();
    send_node(flat, 16'h5100, 2);
    checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_sticky got %b exp 1", fmt_err); end
    checks++; if (got_data.size() != NUM_WORDS || got_data[NUM_WORDS-1] !== flat[(NUM_WORDS-1) * WORD_W +: WORD_W]) begin errors++; $display("FAIL fmt_good_node got %0d words exp %0d", got_data.size(), NUM_WORDS); end
  endtask

  task automatic test_reset_mid_send();
    logic [IMG_W-1:0] flat;
    int n;
    int dones;
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    flat = build_flat();
    n = 0;
    while (nif.ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    nif.valid = 1'b1;
    nif.node  = node_s'(flat[NODE_BITS-1:0]);
    nif.addr  = 16'h6000;
    @(posedge clk); #1;
    nif.valid = 1'b0;
    wif.ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wif.ready = 1'b0;
    checks++; if (wif.data !== flat[2 * WORD_W +: WORD_W] || wif.addr !== 16'h6002) begin errors++; $display("FAIL abort_k2 got %h@%h exp %h@6002", wif.data, wif.addr, flat[2 * WORD_W +: WORD_W]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (nif.ready !== 1'b1)  begin errors++; $display("FAIL abort_node_ready got %b exp 1", nif.ready); end
    checks++; if (wif.valid !== 1'b0)  begin errors++; $display("FAIL abort_word_valid got %b exp 0", wif.valid); end
    checks++; if (wif.data !== '0)     begin errors++; $display("FAIL abort_word_data got %h exp 0", wif.data); end
    checks++; if (wif.addr !== '0)     begin errors++; $display("FAIL abort_word_addr got %h exp 0", wif.addr); end
    checks++; if (wif.last !== 1'b0)   begin errors++; $display("FAIL abort_word_last got %b exp 0", wif.last); end
    checks++; if (node_done !== 1'b0)  begin errors++; $display("FAIL abort_node_done got %b exp 0", node_done); end
    checks++; if (fmt_err !== 1'b0)    begin errors++; $display("FAIL abort_fmt_err got %b exp 0", fmt_err); end
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (node_done !== 1'b0) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dones); end
    rand_fields(MAX_RULES_PER_NODE, MAX_CHILDREN_PER_NODE);
    f_cc = COUNT_W'(MAX_CHILDREN_PER_NODE + 1);
    flat = build_flat();
    send_node(flat, 16'h7000, 0);
    checks++; if (got_data.size() != NUM_WORDS) begin errors++; $display("FAIL restart_count got %0d exp %0d", got_data.size(), NUM_WORDS); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== flat[i * WORD_W +: WORD_W] || got_addr[i] !== ADDR_W'(16'h7000 + i)) begin errors++; $display("FAIL restart_word[%0d] got %h@%h exp %h@%h", i, got_data[i], got_addr[i], flat[i * WORD_W +: WORD_W], 16'h7000 + i); end
    end
    checks++; if (done_now !== 1'b1) begin errors++; $display("FAIL restart_done got %b exp 1", done_now); end
    checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL child_fmt_err got %b exp 1", fmt_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nif.valid = 1'b0;
    nif.node  = '0;
    nif.addr  = '0;
    wif.ready = 1'b0;
    test_reset();
    test_leaf();
    test_round_trip();
    test_stall();
    test_back_to_back();
    test_addr_wrap();
    test_fmt_err();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
